// File: rtl/pipe_alu_if.sv
// Request/result handshake bundle for pipe_alu.
// master drives requests and takes results; slave is the ALU.
interface pipe_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       select;
  logic             mode;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             carry_out;
  logic             compare;
  logic             busy;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output select,
    output mode,
    output carry_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  alu_out,
    input  carry_out,
    input  compare,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  select,
    input  mode,
    input  carry_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output alu_out,
    output carry_out,
    output compare,
    output busy
  );
endinterface

// File: rtl/pipe_alu.sv
// Registered ALU with valid/ready handshake and one result slot.
// Define PIPE_ALU_MUL_EN to add the iterative shift-add multiply.
module pipe_alu #(
  parameter int WIDTH = 16
) (
  input logic   clk,
  input logic   rst,
  pipe_alu_if.slave bus
);

  if (WIDTH < 4 || WIDTH > 64) begin : g_width_chk
    $error("pipe_alu: WIDTH out of range");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd2;
`ifdef PIPE_ALU_MUL_EN
  localparam logic [1:0] MUL  = 2'd1;
  localparam int CW = $clog2(WIDTH);
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] res_q;
  logic             cy_q;
  logic             cmp_q;

  logic out_valid;
  logic busy;
  logic in_ready;
  logic accept;
  logic drain;

  logic [WIDTH-1:0] lres;
  logic             lcy;
  logic [WIDTH:0]   asum;
  logic [WIDTH-1:0] res_d;
  logic             cy_d;

  logic [WIDTH:0] ea;
  logic [WIDTH:0] eb;
  logic [WIDTH:0] na;
  logic [WIDTH:0] nb;
  logic [WIDTH:0] ec;
  logic [WIDTH:0] one;
  logic [WIDTH:0] ones;

  assign out_valid = (state == HOLD);
  assign drain     = out_valid && bus.out_ready;
  assign in_ready  = !busy && (!out_valid || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;

  always_comb begin
    lres = '0;
    lcy  = 1'b0;
    case (bus.select)
      4'h0: lres = bus.in_a;
      4'h1: lres = bus.in_a | bus.in_b;
      4'h2: lres = bus.in_a | ~bus.in_b;
      4'h3: lres = '1;
      4'h4: lres = bus.in_a & bus.in_b;
      4'h5: lres = bus.in_a & ~bus.in_b;
      4'h6: lres = bus.in_a ^ bus.in_b;
      4'h7: lres = ~(bus.in_a ^ bus.in_b);
      4'h8: lres = ~bus.in_a;
      4'h9: lres = bus.in_b;
      4'ha: lres = ~bus.in_b;
      4'hb: lres = '0;
      4'hc: lres = ~(bus.in_a & bus.in_b);
      4'hd: lres = ~(bus.in_a | bus.in_b);
      4'he: begin
        lres = {bus.in_a[WIDTH-2:0], 1'b0};
        lcy  = bus.in_a[WIDTH-1];
      end
      default: begin
        lres = {1'b0, bus.in_a[WIDTH-1:1]};
        lcy  = bus.in_a[0];
      end
    endcase
  end

  // Subtractions are A + ~B + 1, so bit WIDTH reads as "no borrow".
  assign ea   = {1'b0, bus.in_a};
  assign eb   = {1'b0, bus.in_b};
  assign na   = {1'b0, ~bus.in_a};
  assign nb   = {1'b0, ~bus.in_b};
  assign ec   = {{WIDTH{1'b0}}, bus.carry_in};
  assign one  = {{WIDTH{1'b0}}, 1'b1};
  assign ones = {1'b0, {WIDTH{1'b1}}};

  always_comb begin
    asum = '0;
    case (bus.select)
      4'h0: asum = ea + eb + ec;
      4'h1: asum = ea + nb + ec;
      4'h2: asum = ea + one;
      4'h3: asum = ea + ones;
      4'h4: asum = eb + na + one;
      4'h5: asum = na + one;
      4'h6: asum = ea + eb;
      4'h7: asum = ea + nb + one;
      4'h8: asum = ea + ec;
      default: asum = '0;
    endcase
  end

  always_comb begin
    res_d = lres;
    cy_d  = lcy;
    if (bus.mode) begin
      res_d = asum[WIDTH-1:0];
      cy_d  = asum[WIDTH];
    end
  end

`ifdef PIPE_ALU_MUL_EN
  logic                 is_mul;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   pnext;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 last;

  assign is_mul = bus.mode && (bus.select == 4'hf);
  assign busy   = (state == MUL);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign pnext  = prod + (mplier[0] ? mcand : '0);
`else
  assign busy   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      res_q  <= '0;
      cy_q   <= 1'b0;
      cmp_q  <= 1'b0;
`ifdef PIPE_ALU_MUL_EN
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else if (accept) begin
      cmp_q <= (bus.in_a == bus.in_b);
`ifdef PIPE_ALU_MUL_EN
      if (is_mul) begin
        state  <= MUL;
        prod   <= '0;
        mcand  <= {{WIDTH{1'b0}}, bus.in_a};
        mplier <= bus.in_b;
        cnt    <= '0;
      end else begin
        state <= HOLD;
        res_q <= res_d;
        cy_q  <= cy_d;
      end
`else
      state <= HOLD;
      res_q <= res_d;
      cy_q  <= cy_d;
`endif
    end
`ifdef PIPE_ALU_MUL_EN
    else if (busy) begin
      prod   <= pnext;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) begin
        state <= HOLD;
        res_q <= pnext[WIDTH-1:0];
        cy_q  <= |pnext[2*WIDTH-1:WIDTH];
      end
    end
`endif
    else if (drain) begin
      state <= IDLE;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.alu_out   = res_q;
  assign bus.carry_out = cy_q;
  assign bus.compare   = cmp_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_pipe_alu.sv
// Directed self-checking bench for pipe_alu at WIDTH=16.
// Multiply expectations follow whether PIPE_ALU_MUL_EN is defined.
module tb_pipe_alu;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipe_alu_if #(.WIDTH(16)) bus ();

  pipe_alu #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [3:0]  s;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] r;
    logic        y;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [0:NV-1] = '{
    '{1'b1, 4'h0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1},
    '{1'b0, 4'h2, 16'h00F0, 16'hFF00, 1'b0, 16'h00FF, 1'b0},
    '{1'b0, 4'h6, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0},
    '{1'b0, 4'h1, 16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 1'b0},
    '{1'b0, 4'h4, 16'hFF0F, 16'h0FF0, 1'b0, 16'h0F00, 1'b0},
    '{1'b0, 4'h7, 16'h00FF, 16'h0F0F, 1'b0, 16'hF00F, 1'b0},
    '{1'b0, 4'hE, 16'h8001, 16'h0000, 1'b0, 16'h0002, 1'b1},
    '{1'b0, 4'hF, 16'h8001, 16'h0000, 1'b0, 16'h4000, 1'b1},
    '{1'b1, 4'h7, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0},
    '{1'b1, 4'h1, 16'h0010, 16'h0001, 1'b1, 16'h000F, 1'b1},
    '{1'b1, 4'h3, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0},
    '{1'b1, 4'h4, 16'h0003, 16'h0009, 1'b0, 16'h0006, 1'b1},
    '{1'b1, 4'h5, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 1'b0},
    '{1'b1, 4'h8, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1},
    '{1'b1, 4'hA, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b0},
    '{1'b0, 4'hD, 16'h00F0, 16'h0F00, 1'b0, 16'hF00F, 1'b0},
    '{1'b1, 4'h0, 16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0},
    '{1'b1, 4'h2, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1}
  };

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [3:0] s,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic c);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.select   = s;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.carry_in = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int seen;
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h0, 16'h0001, 16'h0001, 1'b0);
    tick();
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_alu_out", 64'(bus.alu_out), 64'd0);
    chk("rst_carry", 64'(bus.carry_out), 64'd0);
    chk("rst_compare", 64'(bus.compare), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // back-to-back accepts with the consumer always ready
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].m, vt[i].s, vt[i].a, vt[i].b, vt[i].c);
      chk($sformatf("b2b_in_ready_%0d", i), 64'(bus.in_ready), 64'd1);
      tick();
      chk($sformatf("vec_valid_%0d", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("vec_out_%0d", i), 64'(bus.alu_out), 64'(vt[i].r));
      chk($sformatf("vec_carry_%0d", i), 64'(bus.carry_out), 64'(vt[i].y));
      chk($sformatf("vec_cmp_%0d", i), 64'(bus.compare),
          64'(vt[i].a == vt[i].b));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_idle", 64'(bus.out_valid), 64'd0);

    // stall: result held, new request waits
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h6, 16'h0003, 16'h0004, 1'b0);
    tick();
    chk("stall_first", 64'(bus.alu_out), 64'h7);
    drive(1'b1, 4'h0, 16'h0001, 16'h0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_ready_%0d", i), 64'(bus.in_ready), 64'd0);
      chk($sformatf("stall_out_%0d", i), 64'(bus.alu_out), 64'h7);
      chk($sformatf("stall_valid_%0d", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("stall_cmp_%0d", i), 64'(bus.compare), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("drain_accept_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("drain_accept_out", 64'(bus.alu_out), 64'h2);
    chk("drain_accept_cmp", 64'(bus.compare), 64'd1);
    chk("drain_accept_valid", 64'(bus.out_valid), 64'd1);
    tick();

    // reset while a result is held
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h0, 16'h0005, 16'h0005, 1'b0);
    tick();
    chk("hold_before_rst", 64'(bus.out_valid), 64'd1);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h0, 16'h0002, 16'h0002, 1'b0);
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("hold_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("hold_rst_out", 64'(bus.alu_out), 64'd0);
    chk("hold_rst_cmp", 64'(bus.compare), 64'd0);
    chk("hold_rst_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("hold_rst_quiet", 64'(bus.out_valid), 64'd0);

`ifdef PIPE_ALU_MUL_EN
    drive(1'b1, 4'hF, 16'h0100, 16'h0100, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("mul_ready_low", 64'(bus.in_ready), 64'd0);
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    chk("mul_busy_cycles", 64'(n), 64'd16);
    chk("mul1_valid", 64'(bus.out_valid), 64'd1);
    chk("mul1_out", 64'(bus.alu_out), 64'h0);
    chk("mul1_carry", 64'(bus.carry_out), 64'd1);
    chk("mul1_cmp", 64'(bus.compare), 64'd1);
    drive(1'b1, 4'hF, 16'h0003, 16'h0005, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("mul2_cycles", 64'(n), 64'd16);
    chk("mul2_out", 64'(bus.alu_out), 64'hF);
    chk("mul2_carry", 64'(bus.carry_out), 64'd0);
    chk("mul2_cmp", 64'(bus.compare), 64'd0);
    tick();

    // reset on cycle 5 of a multiply
    drive(1'b1, 4'hF, 16'h0003, 16'h0005, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_out", 64'(bus.alu_out), 64'd0);
    chk("mrst_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    chk("mrst_no_result", 64'(seen), 64'd0);
`else
    drive(1'b1, 4'hF, 16'h0100, 16'h0100, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("nomul_valid", 64'(bus.out_valid), 64'd1);
    chk("nomul_out", 64'(bus.alu_out), 64'h0);
    chk("nomul_carry", 64'(bus.carry_out), 64'd0);
    chk("nomul_busy", 64'(bus.busy), 64'd0);
    chk("nomul_cmp", 64'(bus.compare), 64'd1);
    tick();
`endif

    drive(1'b1, 4'h6, 16'h0002, 16'h0003, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("post_valid", 64'(bus.out_valid), 64'd1);
    chk("post_out", 64'(bus.alu_out), 64'h5);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
